// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined shifter: operation encodings.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } shift_op_t;

endpackage

// File: rtl/pipelined_shifter_if.sv
// Operand/result handshake bundle for pipelined_shifter; valid/ready on both sides.
interface pipelined_shifter_if
  import shifter_pkg::*;
#(
  parameter int N = 32
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  shift_op_t    op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Z;
  logic         out_illegal;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, Z, out_illegal
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, Z, out_illegal
  );

endinterface

// File: rtl/shift_stage.sv
// Combinational shift by amt*STEP for one pipeline stage; right shifts insert 'fill'.
// Rotate path exists only when SHIFTER_ROTATE_EN is defined, otherwise op=ROTR yields 0.
module shift_stage
  import shifter_pkg::*;
#(
  parameter  int N    = 32,
  parameter  int STEP = 1,
  localparam int SW   = $clog2(N)
) (
  input  logic [N-1:0]  data,
  input  logic [SW-1:0] amt,
  input  shift_op_t     op,
  input  logic          fill,
  output logic [N-1:0]  result
);

  localparam int           LS   = $clog2(STEP);
  localparam logic [N-1:0] ONES = '1;

  logic [SW-1:0] sh;
  assign sh = amt << LS;

`ifdef SHIFTER_ROTATE_EN
  logic [SW:0] lsh;
  assign lsh = (SW+1)'(N) - {1'b0, sh};
`endif

  always_comb begin
    result = '0;
    case (op)
      OP_SLL:         result = data << sh;
      // SRL and SRA differ only in the fill bit chosen by the caller
      OP_SRL, OP_SRA: result = (data >> sh) | ({N{fill}} & ~(ONES >> sh));
`ifdef SHIFTER_ROTATE_EN
      OP_ROTR:        result = (data >> sh) | (data << lsh);
`endif
      default:        result = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Two-stage shifter (coarse then fine), 2-cycle latency, stages stall under out_ready backpressure.
// Define SHIFTER_ROTATE_EN to enable ROTR; otherwise op=11 returns 0 with out_illegal set.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter  int N  = 32,
  localparam int SW = $clog2(N)
) (
  input logic                clk,
  input logic                rst,
  pipelined_shifter_if.slave bus
);

  localparam int FW = SW / 2;
  localparam int CW = SW - FW;

  logic          s1_valid, s2_valid, s1_ready, s2_ready;
  logic [N-1:0]  coarse_res, s1_next, s1_data, fine_res, z_q;
  logic [FW-1:0] s1_fine;
  shift_op_t     s1_op;
  logic          s1_fill, s1_illegal, ill_q;
  logic          sat, coarse_fill, illegal_in;

  assign s2_ready      = !s2_valid || bus.out_ready;
  assign s1_ready      = !s1_valid || s2_ready;
  assign bus.in_ready  = s1_ready;
  assign bus.out_valid = s2_valid;
  assign bus.Z         = z_q;
  assign bus.out_illegal = ill_q;

  assign sat         = |bus.B[N-1:SW];
  assign coarse_fill = (bus.op == OP_SRA) && bus.A[N-1];

`ifdef SHIFTER_ROTATE_EN
  assign illegal_in = 1'b0;
`else
  assign illegal_in = (bus.op == OP_ROTR);
`endif

  shift_stage #(.N(N), .STEP(1 << FW)) u_coarse (
    .data   (bus.A),
    .amt    ({{FW{1'b0}}, bus.B[SW-1:FW]}),
    .op     (bus.op),
    .fill   (coarse_fill),
    .result (coarse_res)
  );

  // Out-of-range amounts saturate here; the fine stage then leaves all-zero or all-sign intact.
  always_comb begin
    s1_next = coarse_res;
    if (illegal_in) begin
      s1_next = '0;
    end else if (sat && bus.op != OP_ROTR) begin
      s1_next = {N{coarse_fill}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_fine    <= '0;
      s1_op      <= OP_SLL;
      s1_fill    <= 1'b0;
      s1_illegal <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data    <= s1_next;
        s1_fine    <= bus.B[FW-1:0];
        s1_op      <= bus.op;
        s1_fill    <= coarse_fill;
        s1_illegal <= illegal_in;
      end
    end
  end

  shift_stage #(.N(N), .STEP(1)) u_fine (
    .data   (s1_data),
    .amt    ({{CW{1'b0}}, s1_fine}),
    .op     (s1_op),
    .fill   (s1_fill),
    .result (fine_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      z_q      <= '0;
      ill_q    <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        z_q   <= fine_res;
        ill_q <= s1_illegal;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboarded random/directed bench for pipelined_shifter (N=32 main instance, N=8 side instance).
module tb_pipelined_shifter;
  import shifter_pkg::*;

  localparam int N = 32;
`ifdef SHIFTER_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_shifter_if #(.N(N)) bus ();
  pipelined_shifter_if #(.N(8)) bus8 ();

  pipelined_shifter #(.N(N)) dut  (.clk(clk), .rst(rst), .bus(bus));
  pipelined_shifter #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct packed {
    logic         ill;
    logic [N-1:0] z;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Bit-by-bit reference: output bit i is taken from the source bit the operation names.
  function automatic logic [64:0] model(input int n, input logic [63:0] a, input logic [63:0] b,
                                       input logic [1:0] opv);
    logic [63:0] z;
    logic        ill;
    logic        big;
    int          s;
    int          r;
    z   = '0;
    ill = 1'b0;
    big = (b >= 64'(n));
    s   = big ? 0 : int'(b[6:0]);
    r   = int'(b % 64'(n));
    for (int i = 0; i < n; i++) begin
      case (opv)
        2'b00: z[i] = (!big && i >= s) ? a[i-s] : 1'b0;
        2'b01: z[i] = (!big && i + s < n) ? a[i+s] : 1'b0;
        2'b10: z[i] = (!big && i + s < n) ? a[i+s] : a[n-1];
        default: begin
          if (ROT_EN) z[i] = a[(i + r) % n];
          else begin
            z[i] = 1'b0;
            ill  = 1'b1;
          end
        end
      endcase
    end
    return {ill, z};
  endfunction

  // One cycle of stimulus; the expected result is queued only when a transfer happens.
  task automatic step(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [1:0] opv, input logic ordy,
                      input logic [N-1:0] ez, input logic eill, output logic acc);
    @(negedge clk);
    bus.in_valid  = v;
    bus.A         = a;
    bus.B         = b;
    bus.op        = shift_op_t'(opv);
    bus.out_ready = ordy;
    #1;
    acc = 1'b0;
    if (!rst) begin
      check("in_ready", 64'(bus.in_ready), 64'(!(sbq.size() == 2 && !ordy)));
      acc = v && bus.in_ready;
      if (acc) sbq.push_back('{ill: eill, z: ez});
    end
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, '0, '0, 2'b00, ordy, '0, 1'b0, acc);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 30 && sbq.size() != 0; k++) idle(1'b1);
    repeat (3) idle(1'b1);
    check(name, 64'(sbq.size()), 64'd0);
  endtask

  // Reset with in_valid held high; nothing offered during reset may ever emerge.
  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.A         = 32'h1234_5678;
    bus.B         = '0;
    bus.op        = OP_SLL;
    bus.out_ready = 1'b0;
    sbq.delete();
    @(negedge clk);
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_z", 64'(bus.Z), 64'd0);
    check("rst_illegal", 64'(bus.out_illegal), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] opv,
                      input logic [7:0] ez, input logic eill, input string name);
    @(negedge clk);
    bus8.in_valid  = 1'b1;
    bus8.A         = a;
    bus8.B         = b;
    bus8.op        = shift_op_t'(opv);
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check({name, "_valid"}, 64'(bus8.out_valid), 64'd1);
    check(name, 64'({bus8.out_illegal, bus8.Z}), 64'({eill, ez}));
  endtask

  // Output monitor: pops on every output transfer and checks held data during stalls.
  initial begin : monitor
    exp_t         e;
    logic         stalled;
    logic [N-1:0] held_z;
    logic         held_ill;
    stalled  = 1'b0;
    held_z   = '0;
    held_ill = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", 64'(bus.out_valid), 64'd1);
          check("hold_z", 64'({bus.out_illegal, bus.Z}), 64'({held_ill, held_z}));
        end
        stalled = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
          if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_output: got Z=0x%0h, expected no output", bus.Z);
          end else begin
            e = sbq.pop_front();
            check("result", 64'({bus.out_illegal, bus.Z}), 64'({e.ill, e.z}));
          end
        end else if (bus.out_valid) begin
          stalled  = 1'b1;
          held_z   = bus.Z;
          held_ill = bus.out_illegal;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic         acc;
    logic         v, ordy, saw_drop;
    logic [N-1:0] a, b;
    logic [1:0]   opv;
    logic [64:0]  m;
    int           i;

    bus.in_valid   = 1'b0;
    bus.A          = '0;
    bus.B          = '0;
    bus.op         = OP_SLL;
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.A         = '0;
    bus8.B         = '0;
    bus8.op        = OP_SLL;
    bus8.out_ready = 1'b1;

    do_reset();

    // Latency: presented in cycle c, out_valid rises two cycles later
    step(1'b1, 32'h0000_0001, 32'd31, 2'b00, 1'b1, 32'h8000_0000, 1'b0, acc);
    idle(1'b1);
    check("lat_cycle1", 64'(bus.out_valid), 64'd0);
    idle(1'b1);
    check("lat_cycle2", 64'(bus.out_valid), 64'd1);

    step(1'b1, 32'h8000_00F0, 32'd4,       2'b10, 1'b1, 32'hF800_000F, 1'b0, acc);
    step(1'b1, 32'h8000_00F0, 32'h20,      2'b10, 1'b1, 32'hFFFF_FFFF, 1'b0, acc);
    step(1'b1, 32'hFFFF_FFFF, 32'h1_0000,  2'b01, 1'b1, 32'h0000_0000, 1'b0, acc);
    if (ROT_EN) step(1'b1, 32'h0000_00AB, 32'd36, 2'b11, 1'b1, 32'hB000_000A, 1'b0, acc);
    else        step(1'b1, 32'h0000_00AB, 32'd36, 2'b11, 1'b1, 32'h0000_0000, 1'b1, acc);
    for (int k = 0; k < 4; k++) begin
      a = $urandom;
      step(1'b1, a, '0, 2'(k), 1'b1, (k == 3 && !ROT_EN) ? '0 : a, k == 3 && !ROT_EN, acc);
    end
    drain("drain_directed");

    // Back-to-back stream with a backpressure window
    i = 0;
    saw_drop = 1'b0;
    for (int c = 0; c < 40 && i < 8; c++) begin
      ordy = !(c >= 3 && c <= 6);
      step(1'b1, 32'h1, 32'(i), 2'b00, ordy, 32'h1 << i, 1'b0, acc);
      if (!bus.in_ready) saw_drop = 1'b1;
      if (acc) i++;
    end
    check("stream_in_ready_drop", 64'(saw_drop), 64'd1);
    check("stream_accepted", 64'(i), 64'd8);
    drain("drain_stream");

    // Reset with both stages full
    step(1'b1, 32'd5, 32'd1, 2'b00, 1'b0, 32'd10, 1'b0, acc);
    step(1'b1, 32'd7, 32'd2, 2'b00, 1'b0, 32'd28, 1'b0, acc);
    do_reset();
    drain("drain_after_reset");

    for (int c = 0; c < 400; c++) begin
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? $urandom : N'($urandom_range(0, 40));
      opv  = 2'($urandom_range(0, 3));
      m    = model(N, {32'd0, a}, {32'd0, b}, opv);
      step(v, a, b, opv, ordy, m[N-1:0], m[64], acc);
    end
    drain("drain_random");

    run8(8'h80, 8'd7, 2'b10, 8'hFF, 1'b0, "n8_sra");
    run8(8'h81, 8'd0, 2'b00, 8'h81, 1'b0, "n8_sll_zero");
    for (int k = 0; k < 12; k++) begin
      logic [7:0] a8, b8;
      a8  = 8'($urandom);
      b8  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      opv = 2'($urandom_range(0, 3));
      m   = model(8, {56'd0, a8}, {56'd0, b8}, opv);
      run8(a8, b8, opv, m[7:0], m[64], "n8_random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
